// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-bus and decode-side handshake bundle for fetch_unit.
//   ireq_*     : read request to the instruction bus (fetch drives valid/addr)
//   iresp_*    : in-order read data back from the bus, one per accepted request
//   out_*      : instruction + PC presented to decode under valid/ready
//   redirect_* : path change from later stages
// master = fetch unit side, slave = environment (bus, decode, redirect source).
interface fetch_unit_if;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        ireq_ready;
  logic        iresp_valid;
  logic [31:0] iresp_data;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        out_ready;
  logic        redirect_valid;
  logic [63:0] redirect_pc;

  modport master (
    output ireq_valid, ireq_addr, out_valid, out_instr, out_pc,
    input  ireq_ready, iresp_valid, iresp_data, out_ready,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  ireq_valid, ireq_addr, out_valid, out_instr, out_pc,
    output ireq_ready, iresp_valid, iresp_data, out_ready,
           redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the decoder.
// Holds the PC, issues 32-bit reads on the instruction bus, and hands each
// returned word plus its PC to decode under valid/ready. A redirect reloads
// the PC and discards any response still in flight for the old path.
//
// Ports:
//   clk   : clock, all state updates on rising edge
//   rst_n : asynchronous active-low reset
//   fif   : fetch_unit_if.master (ireq_*, iresp_*, out_*, redirect_*)
// Parameter:
//   RESET_PC : PC loaded on reset
//
// Build option:
//   FETCH_PREFETCH_EN : when defined, the output becomes a 2-entry in-order
//   FIFO and requests are issued while (buffered + outstanding + stale) < 2.
//   When undefined, a single request is outstanding at a time and one
//   instruction is held (REQ -> WAIT -> HOLD).
//
// Every output is a register or decoded from registers only; no input
// reaches an output combinationally.
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_unit_if.master  fif
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  // redirect target is word aligned; low two bits are dropped
  logic [63:0] tgt;
  logic        unused_redir_lsb;
  assign tgt              = {fif.redirect_pc[63:2], 2'b00};
  assign unused_redir_lsb = ^fif.redirect_pc[1:0];

  // live is low during reset and for the first cycle after release, so the
  // request line is 0 while rst_n is asserted without a path from rst_n.
  logic live;
  logic acc;

`ifdef FETCH_PREFETCH_EN

  logic [63:0]       pc;      // next address to request
  logic [63:0]       rpc;     // PC of the next non-stale response
  logic [1:0]        cnt;     // buffered entries
  logic [1:0]        osd;     // outstanding live-path requests
  logic [1:0]        stale;   // outstanding responses to drop
  logic [2:0]        stale_n;
  logic [2:0]        occ;
  logic [1:0][31:0]  f_instr;
  logic [1:0][63:0]  f_pc;
  logic              wp, rp;
  logic              take, pop;

  assign occ            = {1'b0, cnt} + {1'b0, osd} + {1'b0, stale};
  assign fif.ireq_valid = live & (occ < 3'd2);
  assign fif.ireq_addr  = pc;
  assign fif.out_valid  = (cnt != 2'd0);
  assign fif.out_instr  = f_instr[rp];
  assign fif.out_pc     = f_pc[rp];

  assign acc  = fif.ireq_valid & fif.ireq_ready;
  // responses return in order, so stale ones always come first
  assign take = fif.iresp_valid & (stale == 2'd0);
  assign pop  = fif.out_valid & fif.out_ready;

  // on redirect everything in flight (including one accepted this cycle)
  // becomes stale, less the response consumed this cycle
  assign stale_n = {1'b0, stale} + {1'b0, osd} + {2'b00, acc}
                 - {2'b00, fif.iresp_valid};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live    <= 1'b0;
      pc      <= RESET_PC;
      rpc     <= RESET_PC;
      cnt     <= 2'd0;
      osd     <= 2'd0;
      stale   <= 2'd0;
      wp      <= 1'b0;
      rp      <= 1'b0;
      f_instr <= {2{NOP}};
      f_pc    <= '0;
    end else begin
      live <= 1'b1;
      if (fif.redirect_valid) begin
        pc    <= tgt;
        rpc   <= tgt;
        cnt   <= 2'd0;
        osd   <= 2'd0;
        stale <= stale_n[1:0];
        wp    <= 1'b0;
        rp    <= 1'b0;
      end else begin
        if (acc) pc <= pc + 64'd4;
        osd <= osd + {1'b0, acc} - {1'b0, take};
        if (fif.iresp_valid && stale != 2'd0) stale <= stale - 2'd1;
        if (take) begin
          f_instr[wp] <= fif.iresp_data;
          f_pc[wp]    <= rpc;
          rpc         <= rpc + 64'd4;
          wp          <= ~wp;
        end
        if (pop) rp <= ~rp;
        cnt <= cnt + {1'b0, take} - {1'b0, pop};
      end
    end
  end

`else

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DRAIN} state_t;

  state_t      state, state_n;
  logic [63:0] pc, pc_n;
  logic [31:0] instr_q;
  logic [63:0] opc_q;
  logic        cap;

  assign fif.ireq_valid = live & (state == S_REQ);
  assign fif.ireq_addr  = pc;
  assign fif.out_valid  = (state == S_HOLD);
  assign fif.out_instr  = instr_q;
  assign fif.out_pc     = opc_q;

  assign acc = fif.ireq_valid & fif.ireq_ready;

  always_comb begin
    state_n = state;
    pc_n    = pc;
    cap     = 1'b0;
    if (fif.redirect_valid) begin
      pc_n = tgt;
      // a request accepted now, or one still awaiting data, leaves a
      // response on the bus that must be dropped before refetching
      case (state)
        S_REQ:   state_n = acc ? S_DRAIN : S_REQ;
        S_WAIT:  state_n = fif.iresp_valid ? S_REQ : S_DRAIN;
        S_DRAIN: state_n = fif.iresp_valid ? S_REQ : S_DRAIN;
        default: state_n = S_REQ;
      endcase
    end else begin
      case (state)
        S_REQ:   if (acc) state_n = S_WAIT;
        S_WAIT:  if (fif.iresp_valid) begin
                   state_n = S_HOLD;
                   cap     = 1'b1;
                   pc_n    = pc + 64'd4;
                 end
        S_HOLD:  if (fif.out_ready) state_n = S_REQ;
        S_DRAIN: if (fif.iresp_valid) state_n = S_REQ;
        default: state_n = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_REQ;
      pc      <= RESET_PC;
      live    <= 1'b0;
      instr_q <= NOP;
      opc_q   <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      live  <= 1'b1;
      if (cap) begin
        instr_q <= fif.iresp_data;
        opc_q   <= pc;
      end
    end
  end

`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit (default build). Stimulus pushes the expected bus
// addresses and decode outputs into queues; a bus model and an output
// monitor pop and compare whenever the DUT hands something over.
// Memory returns {addr[31:2], 2'b11} for each read.
module tb_fetch_unit;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } out_t;

  typedef struct packed {
    logic [63:0] addr;
    logic [7:0]  dly;
  } pend_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if fif();

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fif   (fif)
  );

  int n_chk = 0;
  int n_fail = 0;
  int n_out = 0;
  int n_acc = 0;
  int budget = 0;
  int lat = 0;
  int cyc = 0;

  out_t        exp_out[$];
  logic [63:0] exp_req[$];
  pend_t       bus_q[$];
  int          out_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // ---------------- bus model: responds 'lat' cycles after acceptance
  initial begin
    pend_t p;
    fif.ireq_ready  = 1'b0;
    fif.iresp_valid = 1'b0;
    fif.iresp_data  = '0;
    forever begin
      @(negedge clk);
      fif.iresp_valid = 1'b0;
      if (!rst_n) begin
        bus_q.delete();
        fif.ireq_ready = 1'b0;
      end else begin
        if (bus_q.size() > 0) begin
          p = bus_q.pop_front();
          if (p.dly == 8'd0) begin
            fif.iresp_valid = 1'b1;
            fif.iresp_data  = {p.addr[31:2], 2'b11};
          end else begin
            p.dly = p.dly - 8'd1;
            bus_q.push_front(p);
          end
        end
        fif.ireq_ready = (budget > 0);
        if (fif.ireq_valid && fif.ireq_ready) begin
          budget--;
          n_acc++;
          p.addr = fif.ireq_addr;
          p.dly  = 8'(lat);
          bus_q.push_back(p);
          if (exp_req.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL req_unexpected: got addr %h expected no request", fif.ireq_addr);
          end else begin
            check("req_addr", fif.ireq_addr, exp_req.pop_front());
          end
        end
      end
    end
  end

  // ---------------- output monitor + request stability
  initial begin
    logic        prev_v, prev_r, prev_redir;
    logic [63:0] prev_addr;
    out_t        e;
    prev_v = 1'b0; prev_r = 1'b0; prev_redir = 1'b0; prev_addr = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        if (prev_v && !prev_r && !prev_redir) begin
          check("req_stable_valid", fif.ireq_valid, 1);
          check("req_stable_addr", fif.ireq_addr, prev_addr);
        end
        if (fif.out_valid && fif.out_ready) begin
          if (exp_out.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL out_unexpected: got pc %h instr %h expected nothing", fif.out_pc, fif.out_instr);
          end else begin
            e = exp_out.pop_front();
            check("out_pc", fif.out_pc, e.pc);
            check("out_instr", {32'h0, fif.out_instr}, {32'h0, e.instr});
          end
          out_cyc.push_back(cyc);
          n_out++;
        end
        prev_v     = fif.ireq_valid;
        prev_r     = fif.ireq_ready;
        prev_addr  = fif.ireq_addr;
        prev_redir = fif.redirect_valid;
      end else begin
        prev_v = 1'b0;
      end
    end
  end

  task automatic wait_out(input int n);
    int t = 0;
    while (n_out < n && t < 80) begin step(); t++; end
    check("wait_out", n_out >= n, 1);
  endtask

  task automatic wait_acc(input int n);
    int t = 0;
    while (n_acc < n && t < 80) begin step(); t++; end
    check("wait_acc", n_acc >= n, 1);
  endtask

  task automatic wait_ov();
    int t = 0;
    while (!fif.out_valid && t < 80) begin step(); t++; end
    check("wait_out_valid", fif.out_valid, 1);
  endtask

  task automatic exp_pair(input logic [63:0] pc, input logic [31:0] instr);
    out_t e;
    e.pc = pc;
    e.instr = instr;
    exp_out.push_back(e);
  endtask

  // ---------------- stimulus
  initial begin
    int a;
    fif.out_ready      = 1'b1;
    fif.redirect_valid = 1'b0;
    fif.redirect_pc    = '0;
    rst_n = 1'b0;
    repeat (3) step();

    check("rst_ireq_valid", fif.ireq_valid, 0);
    check("rst_out_valid", fif.out_valid, 0);
    check("rst_out_instr", {32'h0, fif.out_instr}, 64'h13);
    check("rst_out_pc", fif.out_pc, 0);
    check("rst_ireq_addr", fif.ireq_addr, RESET_PC);

    // zero-wait streaming from reset
    exp_req.push_back(64'h8000_0000);
    exp_req.push_back(64'h8000_0004);
    exp_req.push_back(64'h8000_0008);
    exp_pair(64'h8000_0000, 32'h8000_0003);
    exp_pair(64'h8000_0004, 32'h8000_0007);
    exp_pair(64'h8000_0008, 32'h8000_000B);
    budget = 3;
    lat = 0;
    rst_n = 1'b1;
    step();
    check("post_rst_ireq_valid", fif.ireq_valid, 1);
    check("post_rst_ireq_addr", fif.ireq_addr, RESET_PC);
    wait_out(3);
    if (out_cyc.size() >= 3) begin
      check("thruput_0_1", out_cyc[1] - out_cyc[0], 3);
      check("thruput_1_2", out_cyc[2] - out_cyc[1], 3);
    end

    // decode stalls in HOLD
    fif.out_ready = 1'b0;
    exp_req.push_back(64'h8000_000C);
    exp_pair(64'h8000_000C, 32'h8000_000F);
    budget = 1;
    wait_ov();
    repeat (5) begin
      step();
      check("hold_out_valid", fif.out_valid, 1);
      check("hold_out_pc", fif.out_pc, 64'h8000_000C);
      check("hold_out_instr", {32'h0, fif.out_instr}, 64'h8000_000F);
      check("hold_ireq_valid", fif.ireq_valid, 0);
    end
    fif.out_ready = 1'b1;
    wait_out(4);

    // redirect while waiting; stale response lands two cycles later
    a = n_acc;
    exp_req.push_back(64'h8000_0010);
    budget = 1;
    lat = 2;
    wait_acc(a + 1);
    step();
    fif.redirect_valid = 1'b1;
    fif.redirect_pc    = 64'h8000_1002;
    step();
    fif.redirect_valid = 1'b0;
    check("redir_wait_out_valid", fif.out_valid, 0);
    lat = 0;
    exp_req.push_back(64'h8000_1000);
    exp_pair(64'h8000_1000, 32'h8000_1003);
    budget = 1;
    wait_out(5);

    // redirect coinciding with the response
    a = n_acc;
    exp_req.push_back(64'h8000_1004);
    budget = 1;
    wait_acc(a + 1);
    step();
    fif.redirect_valid = 1'b1;
    fif.redirect_pc    = 64'h8000_2000;
    exp_req.push_back(64'h8000_2000);
    exp_pair(64'h8000_2000, 32'h8000_2003);
    step();
    fif.redirect_valid = 1'b0;
    check("redir_resp_out_valid", fif.out_valid, 0);
    check("redir_resp_ireq_valid", fif.ireq_valid, 1);
    check("redir_resp_ireq_addr", fif.ireq_addr, 64'h8000_2000);
    budget = 1;
    wait_out(6);

    // redirect while holding an unconsumed instruction
    fif.out_ready = 1'b0;
    exp_req.push_back(64'h8000_2004);
    budget = 1;
    wait_ov();
    fif.redirect_valid = 1'b1;
    fif.redirect_pc    = 64'h8000_3000;
    step();
    fif.redirect_valid = 1'b0;
    check("redir_hold_out_valid", fif.out_valid, 0);
    check("redir_hold_ireq_valid", fif.ireq_valid, 1);
    check("redir_hold_ireq_addr", fif.ireq_addr, 64'h8000_3000);
    fif.out_ready = 1'b1;

    // top of address space, low bits of target ignored, PC wraps to 0
    fif.redirect_valid = 1'b1;
    fif.redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    fif.redirect_valid = 1'b0;
    check("wrap_ireq_addr", fif.ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    exp_req.push_back(64'hFFFF_FFFF_FFFF_FFFC);
    exp_req.push_back(64'h0);
    exp_pair(64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFF);
    exp_pair(64'h0, 32'h0000_0003);
    budget = 2;
    wait_out(8);

    // asynchronous reset in the middle of a wait
    a = n_acc;
    exp_req.push_back(64'h4);
    budget = 1;
    lat = 3;
    wait_acc(a + 1);
    step();
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", fif.out_valid, 0);
    check("async_rst_ireq_valid", fif.ireq_valid, 0);
    check("async_rst_ireq_addr", fif.ireq_addr, RESET_PC);
    lat = 0;
    repeat (2) step();
    exp_req.push_back(RESET_PC);
    exp_pair(RESET_PC, 32'h8000_0003);
    budget = 1;
    rst_n = 1'b1;
    wait_out(9);

    repeat (4) step();
    check("req_queue_empty", exp_req.size(), 0);
    check("out_queue_empty", exp_out.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
